// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's MEM-stage data port.
//
// The block backs a word RAM and a small MMIO window that holds four
// registers: CYCLE, STORES, STATUS (W1C error bits) and GPIO. Stores
// commit on the rising edge of clk. Loads are combinational, so the core's
// MEM/WB register captures the load data at the end of the same cycle.
//
// Parameters:
//   DEPTH_WORDS  RAM size in 32-bit words. Must be a power of two, >= 4.
//   MMIO_BASE    Base address of the MMIO window. addr[31] selects the
//                window, and addr[3:2] selects a register in it.
//
// Ports:
//   clk, rst     Single clock. rst is an asynchronous, active-high reset.
//   mem_w_en     Store request for this cycle.
//   mem_addr     Byte address.
//   mem_w_data   Store data.
//   mem_r_data   Load data, combinational from mem_addr and current state.
//   gpio_out     Value of the GPIO register.
//   err_irq      OR of the STATUS error bits.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_w_data,
  output logic [31:0] mem_r_data,
  output logic [7:0]  gpio_out,
  output logic        err_irq
);
  localparam int AW = $clog2(DEPTH_WORDS);

  // RAM contents are deliberately not reset.
  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] cycle_q,  cycle_d;
  logic [31:0] stores_q, stores_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  gpio_q,   gpio_d;
  logic        ram_we;

  // Address decode. Classes are checked in priority order:
  // misaligned, then MMIO, then RAM, then out-of-range.
  logic          mis, mmio, ram_hit, oor, reg_hit;
  logic [28:0]   word_addr;
  logic [AW-1:0] idx;
  logic [1:0]    reg_sel;

  assign word_addr = mem_addr[30:2];
  assign mis       = |mem_addr[1:0];
  assign mmio      = !mis && mem_addr[31];
  // A word address is in range when all bits above the RAM index are zero.
  assign ram_hit   = !mis && !mem_addr[31] && ((word_addr >> AW) == 29'd0);
  assign oor       = !mis && !mem_addr[31] && !ram_hit;
  // Only the first 16 bytes of the MMIO window hold registers. The rest of
  // the window reads as 0 and ignores writes.
  assign reg_hit   = mmio && (mem_addr[30:4] == MMIO_BASE[30:4]);
  assign idx       = mem_addr[AW+1:2];
  assign reg_sel   = mem_addr[3:2];

  // Load path. Reads have no side effects. During a store, a read returns
  // the pre-edge state.
  always_comb begin
    mem_r_data = '0;
    if (ram_hit) begin
      mem_r_data = ram[idx];
    end else if (reg_hit) begin
      case (reg_sel)
        2'd0:    mem_r_data = cycle_q;
        2'd1:    mem_r_data = stores_q;
        2'd2:    mem_r_data = {30'd0, status_q};
        default: mem_r_data = {24'd0, gpio_q};
      endcase
    end
  end

  // Next-state logic. A single store touches exactly one address class, so
  // the paths that set error bits and the W1C clear of STATUS never collide.
  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    stores_d = stores_q;
    status_d = status_q;
    gpio_d   = gpio_q;
    ram_we   = 1'b0;
    if (mem_w_en) begin
      if (mis) begin
        status_d[0] = 1'b1;
      end else if (oor) begin
        status_d[1] = 1'b1;
      end else if (ram_hit) begin
        ram_we = 1'b1;
        // STORES saturates instead of wrapping.
        if (stores_q != '1) stores_d = stores_q + 32'd1;
      end else if (reg_hit) begin
        case (reg_sel)
          2'd2:    status_d = status_q & ~mem_w_data[1:0];
          2'd3:    gpio_d   = mem_w_data[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= '0;
      stores_q <= '0;
      status_q <= '0;
      gpio_q   <= '0;
    end else begin
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      status_q <= status_d;
      gpio_q   <= gpio_d;
    end
  end

  // A store presented while rst is high is dropped, and the RAM is otherwise
  // untouched by reset.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[idx] <= mem_w_data;
  end

  assign gpio_out = gpio_q;
  assign err_irq  = |status_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Inputs are driven on the falling edge. Combinational reads are sampled
// 1 ns later, before the rising edge that commits the cycle.
module tb_dmem_responder;
  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_w_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_w_data = '0;
  logic [31:0] mem_r_data;
  logic [7:0]  gpio_out;
  logic        err_irq;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] cyc_snap;

  dmem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .clk(clk), .rst(rst), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .gpio_out(gpio_out), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one access for the coming cycle, then let the combinational
  // outputs settle.
  task automatic drv(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_w_en = w; mem_addr = a; mem_w_data = d;
    #1;
  endtask

  initial begin
    // Outputs while reset is held.
    drv(1'b0, MB, 32'h0);
    chk("rst_cycle", mem_r_data, 32'h0);
    chk("rst_gpio", {24'd0, gpio_out}, 32'h0);
    chk("rst_irq", {31'd0, err_irq}, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("cycle0", mem_r_data, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drv(1'b0, MB, 32'h0);
      chk("cycle_run", mem_r_data, i);
    end
    // Reset asserted mid-run clears CYCLE immediately. Counting restarts on
    // the first edge after release.
    @(negedge clk); rst = 1'b1; #1;
    chk("cycle_async_rst", mem_r_data, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("cycle_after_rst", mem_r_data, 32'd0);
    drv(1'b0, MB, 32'h0);
    chk("cycle_after_rst1", mem_r_data, 32'd1);

    // RAM: write word 0, then write 0x10 twice to observe read-during-write.
    drv(1'b1, 32'h0, 32'h1111_1111);
    drv(1'b1, 32'h10, 32'h1234_5678);
    drv(1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("rdw_old", mem_r_data, 32'h1234_5678);
    drv(1'b0, 32'h10, 32'h0);
    chk("ram_new", mem_r_data, 32'hDEAD_BEEF);
    drv(1'b0, MB + 32'h4, 32'h0);
    chk("stores3", mem_r_data, 32'd3);

    // Misaligned store, followed by a W1C clear.
    drv(1'b1, 32'h13, 32'hFFFF_FFFF);
    drv(1'b0, 32'h10, 32'h0);
    chk("mis_no_write", mem_r_data, 32'hDEAD_BEEF);
    chk("mis_irq", {31'd0, err_irq}, 32'h1);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("status_mis", mem_r_data, 32'h1);
    drv(1'b1, MB + 32'h8, 32'h1);
    chk("irq_until_edge", {31'd0, err_irq}, 32'h1);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("status_clr", mem_r_data, 32'h0);
    chk("irq_clr", {31'd0, err_irq}, 32'h0);

    // Out-of-range store at DEPTH_WORDS*4. It must not alias onto word 0.
    drv(1'b1, 32'h1000, 32'h5555_5555);
    drv(1'b0, 32'h1000, 32'h0);
    chk("oor_read", mem_r_data, 32'h0);
    drv(1'b0, 32'h0, 32'h0);
    chk("oor_no_alias", mem_r_data, 32'h1111_1111);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("status_oor", mem_r_data, 32'h2);
    drv(1'b0, 32'h11, 32'h0);
    chk("mis_read", mem_r_data, 32'h0);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("status_kept", mem_r_data, 32'h2);
    // Misaligned store to a STATUS address sets MIS and does not clear OOR.
    drv(1'b1, MB + 32'h9, 32'h3);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("status_mis_on_status", mem_r_data, 32'h3);
    drv(1'b1, MB + 32'h8, 32'h2);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("w1c_bit1_only", mem_r_data, 32'h1);
    drv(1'b1, MB + 32'h8, 32'h1);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("w1c_bit0", mem_r_data, 32'h0);

    // GPIO register.
    drv(1'b1, MB + 32'hC, 32'hFFFF_FFA5);
    drv(1'b0, MB + 32'hC, 32'h0);
    chk("gpio_read", mem_r_data, 32'h0000_00A5);
    chk("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
    // Stores outside the register block are ignored, even when the low
    // offset matches GPIO.
    drv(1'b1, MB + 32'h1C, 32'h0000_0077);
    drv(1'b0, MB + 32'h1C, 32'h0);
    chk("mmio_hole_read", mem_r_data, 32'h0);
    chk("mmio_hole_gpio", {24'd0, gpio_out}, 32'h0000_00A5);
    // A store to CYCLE is ignored: the counter keeps counting.
    drv(1'b1, MB, 32'h0);
    cyc_snap = mem_r_data;
    drv(1'b0, MB, 32'h0);
    chk("cycle_ro", mem_r_data, cyc_snap + 32'd1);
    drv(1'b0, MB + 32'h8, 32'h0);
    chk("mmio_no_err", mem_r_data, 32'h0);
    drv(1'b0, MB + 32'h4, 32'h0);
    chk("stores_mmio_ignored", mem_r_data, 32'd3);

    // Reset clears the registers. A store presented during reset is dropped,
    // and RAM contents survive reset.
    drv(1'b1, 32'h2, 32'h0);
    @(negedge clk); rst = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h10; mem_w_data = 32'h0; #1;
    chk("rst2_gpio", {24'd0, gpio_out}, 32'h0);
    chk("rst2_irq", {31'd0, err_irq}, 32'h0);
    @(negedge clk); rst = 1'b0; mem_w_en = 1'b0; #1;
    chk("ram_survives_rst", mem_r_data, 32'hDEAD_BEEF);
    drv(1'b0, MB + 32'h4, 32'h0);
    chk("rst2_stores", mem_r_data, 32'h0);

    // STORES saturation, preset through a backdoor force.
    @(negedge clk); force dut.stores_q = 32'hFFFF_FFFE;
    @(negedge clk); release dut.stores_q;
    drv(1'b0, MB + 32'h4, 32'h0);
    chk("stores_preset", mem_r_data, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) drv(1'b1, 32'h20 + 32'(i * 4), 32'(i));
    drv(1'b0, MB + 32'h4, 32'h0);
    chk("stores_sat", mem_r_data, 32'hFFFF_FFFF);
    drv(1'b0, MB + 32'h4, 32'h0);
    chk("stores_sat_hold", mem_r_data, 32'hFFFF_FFFF);
    drv(1'b0, 32'h28, 32'h0);
    chk("ram_last", mem_r_data, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
